// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the datapath and the data-memory responder.
// The datapath drives the request side; the responder returns data and status.
interface data_mem_responder_if;
    logic        memRead;
    logic        memWrite;
    logic [63:0] addr;
    logic [63:0] writeData;
    logic [63:0] readData;
    logic        stall;
    logic        done;
    logic        fault;

    modport master (
        output memRead, memWrite, addr, writeData,
        input  readData, stall, done, fault
    );

    modport slave (
        input  memRead, memWrite, addr, writeData,
        output readData, stall, done, fault
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle ld/sd doubleword responder: stalls the pipe while an access is
// in flight, then pulses done for one cycle with registered load data.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input logic                  clk,
    input logic                  reset_n,
    data_mem_responder_if.slave  bus
);

    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BW    = ADDR_WIDTH - 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [BW-1:0] base_q, base_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;

    logic [7:0]    mem [DEPTH];
    logic [63:0]   mem_word;
    logic          mem_we;
    logic          req;
    logic          bad;
    logic          idle;

    assign req  = bus.memRead | bus.memWrite;
    assign bad  = (bus.memRead & bus.memWrite)
                | (|bus.addr[2:0])
                | (|bus.addr[63:ADDR_WIDTH]);
    assign idle = (state_q == IDLE);

    // Accesses are doubleword aligned, so only the word base is kept.
    always_comb begin
        mem_word = '0;
        for (int k = 0; k < 8; k++) begin
            mem_word[8*k +: 8] = mem[{base_q, 3'(k)}];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !bad) begin
                    wr_d    = bus.memWrite;
                    base_d  = bus.addr[ADDR_WIDTH-1:3];
                    wdata_d = bus.writeData;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = RESP;
                    if (wr_q) mem_we  = 1'b1;
                    else      rdata_d = mem_word;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage survives reset; an aborted store never reaches BUSY's last cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                mem[{base_q, 3'(k)}] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign bus.readData = rdata_q;
    assign bus.done     = (state_q == RESP);
    assign bus.stall    = reset_n & ((idle & req & ~bad) | (state_q == BUSY));
    assign bus.fault    = reset_n & idle & req & bad;

endmodule
